// File: rtl/comb_tt_checker.sv
// comb_tt_checker: captures a combinational DUT's truth table sample by
// sample and scores it against an expected table.
module comb_tt_checker #(
   parameter int          N_IN   = 4,
   parameter logic [15:0] EXPECT = 16'h0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [N_IN-1:0]   in_idx,
   input  logic              in_y,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              seq_err,
   output logic [N_IN:0]     err_count,
   output logic              first_err_vld,
   output logic [N_IN-1:0]   first_err_idx,
   output logic [(1<<N_IN)-1:0] table_out
);

   localparam int D  = 1 << N_IN;
   localparam int CW = N_IN + 1;
   localparam logic [D-1:0]  EXP_T = EXPECT[D-1:0];
   localparam logic [CW-1:0] LAST  = CW'(D - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [D-1:0]    r_table,     w_table_nxt;
   logic [CW-1:0]   r_err_cnt,   w_err_nxt;
   logic [CW-1:0]   r_next_idx,  w_next_nxt;
   logic            r_first_vld, w_first_vld_nxt;
   logic [N_IN-1:0] r_first_idx, w_first_idx_nxt;
   logic            r_seq_err,   w_seq_err_nxt;
   logic            r_pass,      w_pass_nxt;
   logic            w_in_order;

   assign w_in_order = ({1'b0, in_idx} == r_next_idx);

   // Next-state and result update; start always wins and clears the run
   always_comb begin
      w_state_nxt     = r_state;
      w_table_nxt     = r_table;
      w_err_nxt       = r_err_cnt;
      w_next_nxt      = r_next_idx;
      w_first_vld_nxt = r_first_vld;
      w_first_idx_nxt = r_first_idx;
      w_seq_err_nxt   = r_seq_err;
      w_pass_nxt      = r_pass;
      if (start) begin
         w_state_nxt     = S_CAPTURE;
         w_table_nxt     = '0;
         w_err_nxt       = '0;
         w_next_nxt      = '0;
         w_first_vld_nxt = 1'b0;
         w_first_idx_nxt = '0;
         w_seq_err_nxt   = 1'b0;
         w_pass_nxt      = 1'b0;
      end else begin
         unique case (r_state)
            S_CAPTURE: begin
               if (in_valid) begin
                  if (w_in_order) begin
                     w_table_nxt[in_idx] = in_y;
                     if (in_y != EXP_T[in_idx]) begin
                        w_err_nxt = r_err_cnt + CW'(1);
                        if (!r_first_vld) begin
                           w_first_vld_nxt = 1'b1;
                           w_first_idx_nxt = in_idx;
                        end
                     end
                     w_next_nxt = r_next_idx + CW'(1);
                     if (r_next_idx == LAST) begin
                        w_state_nxt = S_DONE;
                        w_pass_nxt  = (w_err_nxt == '0);
                     end
                  end else begin
                     w_seq_err_nxt = 1'b1;
                     w_pass_nxt    = 1'b0;
                     w_state_nxt   = S_DONE;
                  end
               end
            end
            S_IDLE:  ;
            S_DONE:  ;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // State and result registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_table     <= '0;
         r_err_cnt   <= '0;
         r_next_idx  <= '0;
         r_first_vld <= 1'b0;
         r_first_idx <= '0;
         r_seq_err   <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_table     <= w_table_nxt;
         r_err_cnt   <= w_err_nxt;
         r_next_idx  <= w_next_nxt;
         r_first_vld <= w_first_vld_nxt;
         r_first_idx <= w_first_idx_nxt;
         r_seq_err   <= w_seq_err_nxt;
         r_pass      <= w_pass_nxt;
      end
   end

   assign busy          = (r_state == S_CAPTURE);
   assign done          = (r_state == S_DONE);
   assign pass          = r_pass;
   assign seq_err       = r_seq_err;
   assign err_count     = r_err_cnt;
   assign first_err_vld = r_first_vld;
   assign first_err_idx = r_first_idx;
   assign table_out     = r_table;

endmodule

// File: tb/tb_comb_tt_checker.sv
// tb_comb_tt_checker: directed vectors against a 3-input and a 4-input
// instance of comb_tt_checker sharing one clock and reset.
module tb_comb_tt_checker;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic       s3 = 0, v3 = 0, y3 = 0;
   logic [2:0] idx3 = '0;
   logic       busy3, done3, pass3, seq3, fv3;
   logic [3:0] cnt3;
   logic [2:0] fi3;
   logic [7:0] tbl3;

   logic        s4 = 0, v4 = 0, y4 = 0;
   logic [3:0]  idx4 = '0;
   logic        busy4, done4, pass4, seq4, fv4;
   logic [4:0]  cnt4;
   logic [3:0]  fi4;
   logic [15:0] tbl4;

   logic [7:0] exp3 = 8'hE8;

   always #5 clk = ~clk;

   comb_tt_checker #(.N_IN(3), .EXPECT(16'h00E8)) u3 (
      .clk(clk), .rst_n(rst_n), .start(s3), .in_valid(v3),
      .in_idx(idx3), .in_y(y3), .busy(busy3), .done(done3),
      .pass(pass3), .seq_err(seq3), .err_count(cnt3),
      .first_err_vld(fv3), .first_err_idx(fi3), .table_out(tbl3)
   );

   comb_tt_checker #(.N_IN(4), .EXPECT(16'h0000)) u4 (
      .clk(clk), .rst_n(rst_n), .start(s4), .in_valid(v4),
      .in_idx(idx4), .in_y(y4), .busy(busy4), .done(done4),
      .pass(pass4), .seq_err(seq4), .err_count(cnt4),
      .first_err_vld(fv4), .first_err_idx(fi4), .table_out(tbl4)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset
      tick();
      tick();
      chk("rst_busy", busy3, 0);
      chk("rst_done", done3, 0);
      chk("rst_pass", pass3, 0);
      chk("rst_cnt", cnt3, 0);
      chk("rst_tbl", tbl3, 0);
      rst_n = 1'b1;
      tick();

      // T1: N=3 matching run
      s3 = 1; tick(); s3 = 0;
      chk("t1_busy", busy3, 1);
      for (int i = 0; i < 8; i++) begin
         v3 = 1; idx3 = 3'(i); y3 = exp3[i];
         tick();
         if (i == 6) chk("t1_notdone", done3, 0);
      end
      chk("t1_done", done3, 1);
      chk("t1_busy0", busy3, 0);
      chk("t1_pass", pass3, 1);
      chk("t1_cnt", cnt3, 0);
      chk("t1_tbl", tbl3, 8'hE8);
      idx3 = 0; y3 = 1; tick(); v3 = 0;
      chk("t1_hold_tbl", tbl3, 8'hE8);
      chk("t1_hold_done", done3, 1);

      // T2: N=4 two mismatches
      s4 = 1; tick(); s4 = 0;
      for (int i = 0; i < 16; i++) begin
         v4 = 1; idx4 = 4'(i); y4 = (i == 5 || i == 11);
         tick();
      end
      v4 = 0;
      chk("t2_done", done4, 1);
      chk("t2_pass", pass4, 0);
      chk("t2_cnt", cnt4, 2);
      chk("t2_fv", fv4, 1);
      chk("t2_fi", fi4, 5);
      chk("t2_tbl", tbl4, 16'h0820);
      chk("t2_seq", seq4, 0);

      // T3: N=3 sequence error on skipped index
      s3 = 1; tick(); s3 = 0;
      chk("t3_clr_done", done3, 0);
      v3 = 1; idx3 = 0; y3 = 1; tick();
      idx3 = 1; y3 = 1; tick();
      chk("t3_pre_done", done3, 0);
      idx3 = 3; y3 = 1; tick(); v3 = 0;
      chk("t3_seq", seq3, 1);
      chk("t3_done", done3, 1);
      chk("t3_pass", pass3, 0);
      chk("t3_tbl", tbl3, 8'h03);
      chk("t3_cnt", cnt3, 2);
      chk("t3_fi", fi3, 0);

      // T4: N=4 with a gap every other cycle
      s4 = 1; tick(); s4 = 0;
      for (int c = 0; c < 31; c++) begin
         v4 = (c % 2 == 0);
         idx4 = 4'(c / 2);
         y4 = !v4;
         tick();
         if (c == 29) chk("t4_notdone30", done4, 0);
         if (c == 14) chk("t4_gap_tbl", tbl4, 0);
      end
      v4 = 0;
      chk("t4_done31", done4, 1);
      chk("t4_pass", pass4, 1);
      chk("t4_tbl", tbl4, 0);

      // T5: restart mid-run, start drops the coincident sample
      s3 = 1; tick(); s3 = 0;
      for (int i = 0; i < 6; i++) begin
         v3 = 1; idx3 = 3'(i); y3 = !exp3[i];
         tick();
      end
      chk("t5_mid_cnt", cnt3, 6);
      s3 = 1; v3 = 1; idx3 = 0; y3 = 1; tick(); s3 = 0;
      chk("t5_rs_busy", busy3, 1);
      chk("t5_rs_cnt", cnt3, 0);
      chk("t5_rs_tbl", tbl3, 0);
      for (int i = 0; i < 8; i++) begin
         v3 = 1; idx3 = 3'(i); y3 = exp3[i];
         tick();
      end
      v3 = 0;
      chk("t5_done", done3, 1);
      chk("t5_pass", pass3, 1);
      chk("t5_cnt", cnt3, 0);
      chk("t5_tbl", tbl3, 8'hE8);

      // T6: async reset mid-capture
      s4 = 1; tick(); s4 = 0;
      for (int i = 0; i < 9; i++) begin
         v4 = 1; idx4 = 4'(i); y4 = (i == 2);
         tick();
      end
      v4 = 0;
      chk("t6_pre_cnt", cnt4, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_busy", busy4, 0);
      chk("t6_cnt", cnt4, 0);
      chk("t6_fv", fv4, 0);
      chk("t6_tbl", tbl4, 0);
      chk("t6_done3", done3, 0);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         v4 = 1; idx4 = 4'(i); y4 = 1;
         tick();
      end
      v4 = 0;
      chk("t6_post_done", done4, 0);
      chk("t6_post_busy", busy4, 0);
      chk("t6_post_tbl", tbl4, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
